// File: rtl/park_controller_pkg.sv
// park_controller_pkg
// Shared definitions for the parking-lot controller: lot geometry, the
// default gate-open time, the entry FSM state encoding and a helper that
// counts free spaces in an occupancy vector.
package park_controller_pkg;

  localparam int NUM_SPACES      = 8;
  localparam int SPACE_W         = 3;
  localparam int GATE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_GATE     = 2'd2,
    ST_WAIT_CLR = 2'd3
  } park_state_e;

  // Number of zero bits in an occupancy vector (0..NUM_SPACES).
  function automatic logic [3:0] count_free(input logic [NUM_SPACES-1:0] occ);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_SPACES; i++) begin
      if (!occ[i]) n = n + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/park_controller_free_finder.sv
// park_free_finder
// Lowest-index priority encoder over the free-space mask.
// Ports:
//   free_mask_i : bit i = 1 when space i is free (i.e. ~occupancy)
//   idx_o       : index of the lowest set bit of free_mask_i (0 when none)
//   valid_o     : 1 when at least one space is free
module park_free_finder
  import park_controller_pkg::*;
(
  input  logic [NUM_SPACES-1:0] free_mask_i,
  output logic [SPACE_W-1:0]    idx_o,
  output logic                  valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_SPACES - 1; i >= 0; i--) begin
      if (free_mask_i[i]) begin
        idx_o   = SPACE_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/park_controller.sv
// park_controller
// Eight-space parking-lot controller. An entry FSM allocates the lowest free
// space to a waiting car and opens the entry barrier for GATE_CYCLES cycles;
// an independent exit path frees spaces on request.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   entry_req             : level, car waiting; held until the gate has closed
//   entry_ack/entry_space : one-cycle grant pulse and allocated index
//   entry_gate            : entry barrier open
//   exit_req/exit_space   : one-cycle exit pulse and the space being vacated
//   exit_ack/exit_error   : one-cycle result pulses for an exit request
//   occupancy             : bit i = 1 when space i is taken
//   free_count/full/empty : combinational status of occupancy
//   dbg_state             : current entry FSM state
// Handshake: entry_req is a level request; it is granted by a single
// entry_ack pulse and must stay high until entry_gate has dropped, after which
// the FSM waits for entry_req=0 before accepting the next car. exit_req is a
// fire-and-forget pulse answered one cycle later by exactly one of exit_ack or
// exit_error.
module park_controller
  import park_controller_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  entry_req,
  output logic                  entry_ack,
  output logic [SPACE_W-1:0]    entry_space,
  output logic                  entry_gate,
  input  logic                  exit_req,
  input  logic [SPACE_W-1:0]    exit_space,
  output logic                  exit_ack,
  output logic                  exit_error,
  output logic [NUM_SPACES-1:0] occupancy,
  output logic [3:0]            free_count,
  output logic                  full,
  output logic                  empty,
  output park_state_e           dbg_state
);

  localparam logic [3:0]            GATE_LOAD = 4'(GATE_CYCLES - 1);
  localparam logic [NUM_SPACES-1:0] ONE_HOT0  = NUM_SPACES'(1);

  park_state_e           state_q;
  logic [3:0]            cnt_q;
  logic                  entry_ack_q;
  logic [SPACE_W-1:0]    entry_space_q;
  logic                  entry_gate_q;
  logic                  exit_ack_q;
  logic                  exit_error_q;
  logic [NUM_SPACES-1:0] occ_q;
  logic [NUM_SPACES-1:0] occ_d;

  logic [SPACE_W-1:0]    free_idx;
  logic                  free_valid;
  logic                  grant;
  logic                  exit_hit;
  logic [NUM_SPACES-1:0] alloc_mask;
  logic [NUM_SPACES-1:0] release_mask;

  park_free_finder u_finder (
    .free_mask_i (~occ_q),
    .idx_o       (free_idx),
    .valid_o     (free_valid)
  );

  // Allocation and release both look at occupancy from before the edge, so a
  // grant never targets the space being freed in the same cycle: the freed
  // bit was occupied, the allocated bit was free.
  always_comb begin
    grant        = (state_q == ST_IDLE) && entry_req && !full && free_valid;
    exit_hit     = exit_req && occ_q[exit_space];
    alloc_mask   = grant ? (ONE_HOT0 << free_idx) : '0;
    release_mask = exit_hit ? (ONE_HOT0 << exit_space) : '0;
    occ_d        = (occ_q & ~release_mask) | alloc_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  // Entry FSM; the latched grant index lives in entry_space_q for the single
  // GRANT cycle and is cleared afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      entry_ack_q   <= 1'b0;
      entry_space_q <= '0;
      entry_gate_q  <= 1'b0;
    end else begin
      entry_ack_q   <= 1'b0;
      entry_space_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q       <= ST_GRANT;
            entry_ack_q   <= 1'b1;
            entry_space_q <= free_idx;
          end
        end
        ST_GRANT: begin
          state_q      <= ST_GATE;
          entry_gate_q <= 1'b1;
          cnt_q        <= GATE_LOAD;
        end
        ST_GATE: begin
          // Counter reaches zero on the last open cycle.
          if (cnt_q == 4'd0) begin
            state_q      <= ST_WAIT_CLR;
            entry_gate_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WAIT_CLR: begin
          if (!entry_req) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Exit path, independent of the entry FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exit_ack_q   <= 1'b0;
      exit_error_q <= 1'b0;
    end else begin
      exit_ack_q   <= exit_hit;
      exit_error_q <= exit_req && !occ_q[exit_space];
    end
  end

  assign entry_ack   = entry_ack_q;
  assign entry_space = entry_space_q;
  assign entry_gate  = entry_gate_q;
  assign exit_ack    = exit_ack_q;
  assign exit_error  = exit_error_q;
  assign occupancy   = occ_q;
  assign free_count  = count_free(occ_q);
  assign full        = (occ_q == {NUM_SPACES{1'b1}});
  assign empty       = (occ_q == '0);
  assign dbg_state   = state_q;

endmodule

// File: doc/park_controller.md
PARK_CONTROLLER -- requirements
Module: park_controller

Interface
REQ-001 Parameter GATE_CYCLES, default 4: number of cycles entry_gate stays high after a grant; legal range 1-15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 entry_req  input  1  car waiting at the entry; level, held until entry_gate has closed.
REQ-005 entry_ack  output  1  one-cycle pulse: space allocated.
REQ-006 entry_space  output  3  allocated space index, valid while entry_ack is high, otherwise 0.
REQ-007 entry_gate  output  1  entry barrier open.
REQ-008 exit_req  input  1  one-cycle pulse: car leaving space exit_space.
REQ-009 exit_space  input  3  space being vacated, sampled when exit_req is high.
REQ-010 exit_ack  output  1  one-cycle pulse: space freed.
REQ-011 exit_error  output  1  one-cycle pulse: exit requested for a space that is already free.
REQ-012 occupancy  output  8  bit i = 1 means space i is occupied.
REQ-013 free_count  output  4  number of free spaces, 0-8.
REQ-014 full  output  1  occupancy == 8'hFF.
REQ-015 empty  output  1  occupancy == 8'h00.

Function
REQ-016 The entry FSM SHALL have the states IDLE, GRANT, GATE and WAIT_CLR.
REQ-017 IDLE -> GRANT SHALL occur when entry_req=1 and full=0; with entry_req=1 and full=1 the FSM SHALL stay in IDLE and hold entry_ack=0.
REQ-018 On the edge entering GRANT, the block SHALL set the lowest-indexed free occupancy bit and latch that index.
REQ-019 In GRANT, entry_ack=1 and entry_space=latched index for exactly one cycle, then the FSM SHALL go to GATE.
REQ-020 In GATE, entry_gate=1 for exactly GATE_CYCLES cycles, counted by a 4-bit down-counter, then the FSM SHALL go to WAIT_CLR.
REQ-021 In WAIT_CLR, entry_gate=0; the FSM SHALL return to IDLE on the first cycle with entry_req=0.
REQ-022 Latency: entry_req rising in IDLE (not full) -> entry_ack one cycle later -> entry_gate high the cycle after that.
REQ-023 Exit handling SHALL run independently of the entry FSM: exit_req=1 with occupancy[exit_space]=1 SHALL clear that bit and give exit_ack=1 on the next cycle.
REQ-024 exit_req=1 with occupancy[exit_space]=0 SHALL leave occupancy unchanged and give exit_error=1 on the next cycle.
REQ-025 Simultaneous allocate and free on the same edge SHALL both take effect; the allocation SHALL use the occupancy value from before that edge.
REQ-026 When full and an exit occur in the same cycle, the pending entry SHALL be granted one cycle later, using the freed space if it is the lowest free index.
REQ-027 free_count, full and empty SHALL be combinational functions of the occupancy register, consistent with it in every cycle.
REQ-028 No occupancy bit SHALL ever be both allocated and freed on the same edge; allocation only targets free bits and freeing only targets occupied bits.

Reset
REQ-029 While rst_n=0, the block SHALL hold: FSM=IDLE, counter=0, occupancy=8'h00, free_count=8, empty=1, full=0, and all pulses, entry_gate and entry_space at 0.
REQ-030 Reset asserted in any state, including mid-GATE, SHALL abort the operation immediately and close the gate; after release, any held entry_req SHALL be treated as a new request.

Structure
REQ-031 A shared include file park_defs.vh SHALL hold NUM_SPACES=8, SPACE_W=3, the FSM state encodings and the GATE_CYCLES default.
REQ-032 One sub-module, park_free_finder, SHALL be used: an 8-to-3 lowest-index priority encoder over ~occupancy, with a valid output.

Verification
REQ-033 Reset release, entry_req held high -> entry_ack at cycle 1 with entry_space=0; entry_gate high for cycles 2-5; occupancy=8'h01; free_count=7.
REQ-034 Eight sequential entries -> entry_space 0..7 in order, full=1, occupancy=8'hFF; a ninth entry_req -> no entry_ack while full.
REQ-035 Full lot with ninth entry_req held, then exit_req with exit_space=5 -> exit_ack, occupancy=8'hDF, then entry_ack with entry_space=5 one cycle later.
REQ-036 Occupancy=8'h03, exit_req with exit_space=6 -> exit_error pulse, occupancy stays 8'h03, exit_ack=0.
REQ-037 Grant to space 2 in the same cycle as exit of space 0 (occupancy=8'h03 before) -> occupancy=8'h06, entry_ack and exit_ack both asserted.
REQ-038 rst_n driven low during cycle 2 of GATE -> entry_gate=0 immediately and occupancy=8'h00; after release with entry_req still high -> new grant of space 0.
